// File: rtl/alu_input_seq.sv
// Operand/opcode entry sequencer: one debounced push-button steps the FSM A -> B -> OP -> SHOW, latching i_sw.
// Optional macro ALU_INPUT_SEQ_DEBOUNCE_EN enables the DEB_CYCLES debouncer; otherwise the synchronised level is registered once.
module alu_input_seq #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_sw,
  input  logic       i_btn,
  input  logic       i_clr,
  output logic [3:0] o_a,
  output logic [3:0] o_b,
  output logic [2:0] o_op,
  output logic       o_valid,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_SHOW = 2'b11
  } state_e;

  logic sync1_q, sync2_q;
  logic stable_q, stable_d, stable_dly_q;
  logic press;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
    end else begin
      sync1_q      <= i_btn;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
    end
  end

`ifdef ALU_INPUT_SEQ_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept the new level only after it has differed for DEB_CYCLES cycles in a row.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  localparam int unused_deb_cycles = DEB_CYCLES;
  assign stable_d = sync2_q;
`endif

  assign press = stable_q & ~stable_dly_q;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = 1'b0;
    if (i_clr) begin
      // Clear wins over a press landing on the same edge; that press is dropped.
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else if (press) begin
      case (state_q)
        S_A: begin
          a_d     = i_sw;
          state_d = S_B;
        end
        S_B: begin
          b_d     = i_sw;
          state_d = S_OP;
        end
        S_OP: begin
          op_d    = i_sw[2:0];
          state_d = S_SHOW;
          valid_d = 1'b1;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign o_a     = a_q;
  assign o_b     = b_q;
  assign o_op    = op_q;
  assign o_valid = valid_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_alu_input_seq.sv
// Directed bench for alu_input_seq with DEB_CYCLES=4; bounce vectors only apply with the debouncer compiled in.
module tb_alu_input_seq;

`ifdef ALU_INPUT_SEQ_DEBOUNCE_EN
  // raw rise -> 2 sync edges -> 4 counting edges -> stable -> FSM edge
  localparam int LAT = 7;
`else
  // raw rise -> 2 sync edges -> stable register -> FSM edge
  localparam int LAT = 4;
`endif

  logic       clk, rst_n, btn, clr;
  logic [3:0] sw, a, b;
  logic [2:0] op;
  logic       valid;
  logic [1:0] state;

  int n_vec = 0;
  int n_bad = 0;
  int vcnt  = 0;
  int vbase;

  alu_input_seq #(.DEB_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw), .i_btn(btn), .i_clr(clr),
    .o_a(a), .o_b(b), .o_op(op), .o_valid(valid), .o_state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (valid) vcnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] v);
    sw  = v;
    btn = 1'b1;
    idle(12);
    btn = 1'b0;
    idle(12);
  endtask

  initial begin
    rst_n = 1'b0; btn = 1'b0; clr = 1'b0; sw = 4'h0;
    idle(3);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_op", op, 0);
    chk("rst_valid", valid, 0);
    chk("rst_state", state, 0);
    rst_n = 1'b1;
    idle(3);

    // clean sequence 3, 5, opcode 0
    vbase = vcnt;
    press(4'h3);
    chk("seq1_state_b", state, 2'b01);
    chk("seq1_a", a, 4'h3);
    sw = 4'h7; idle(5);
    chk("seq1_a_hold", a, 4'h3);
    press(4'h5);
    chk("seq1_state_op", state, 2'b10);
    chk("seq1_b", b, 4'h5);
    press(4'h0);
    chk("seq1_state_show", state, 2'b11);
    chk("seq1_op", op, 3'h0);
    chk("seq1_valid_cnt", vcnt - vbase, 1);
    chk("seq1_valid_low", valid, 0);

    // press in SHOW with F: back to A, operands retained
    vbase = vcnt;
    press(4'hF);
    chk("show_state", state, 2'b00);
    chk("show_a", a, 4'h3);
    chk("show_b", b, 4'h5);
    chk("show_op", op, 3'h0);
    chk("show_valid_cnt", vcnt - vbase, 0);

    // press latency from raw rise
    sw = 4'h2; btn = 1'b1;
    idle(LAT - 1);
    chk("lat_a_before", a, 4'h3);
    chk("lat_state_before", state, 2'b00);
    idle(1);
    chk("lat_a_after", a, 4'h2);
    chk("lat_state_after", state, 2'b01);
    btn = 1'b0; idle(12);

`ifdef ALU_INPUT_SEQ_DEBOUNCE_EN
    // 3-cycle glitches must never reach the FSM
    sw = 4'h9;
    for (int i = 0; i < 3; i++) begin
      btn = 1'b1; idle(3);
      btn = 1'b0; idle(4);
    end
    idle(8);
    chk("bounce_state", state, 2'b01);
    chk("bounce_b", b, 4'h5);
`endif
    press(4'h4);
    chk("steady_state", state, 2'b10);
    chk("steady_b", b, 4'h4);
    vbase = vcnt;
    press(4'hE);
    chk("op_trunc", op, 3'h6);
    chk("op_state", state, 2'b11);
    chk("op_valid_cnt", vcnt - vbase, 1);
    press(4'h1);
    chk("wrap_state", state, 2'b00);

    // clear on the same edge as a press in OP
    press(4'h1);
    press(4'h2);
    chk("clr_pre_state", state, 2'b10);
    vbase = vcnt;
    sw = 4'h5; btn = 1'b1;
    idle(LAT - 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("clr_state", state, 2'b00);
    chk("clr_a", a, 0);
    chk("clr_b", b, 0);
    chk("clr_op", op, 0);
    idle(2);
    btn = 1'b0; idle(12);
    chk("clr_lost_state", state, 2'b00);
    chk("clr_valid_cnt", vcnt - vbase, 0);

    // half-cycle async reset in B
    press(4'h3);
    chk("ar_pre_state", state, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("ar_a", a, 0);
    chk("ar_state", state, 2'b00);
    #3;
    rst_n = 1'b1;
    idle(3);
    chk("ar_hold_state", state, 2'b00);

    // reset released with button held: exactly one press
    sw = 4'h9; btn = 1'b1;
    rst_n = 1'b0; idle(2);
    rst_n = 1'b1;
    idle(20);
    chk("rbtn_state", state, 2'b01);
    chk("rbtn_a", a, 4'h9);
    btn = 1'b0; idle(12);
    chk("rbtn_rel_state", state, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
